// File: rtl/pwm_measure_sequencer.sv
// rtl/pwm_measure_sequencer.sv - PWM pulse-width measurement sequencer with LOW/MID/HIGH classification
//
// Arms on enable, throws away any pulse already in progress, then times the high
// phase of each following pulse and reports it once per pulse. Also flags pulses
// that saturate the width counter and reports a periodic timeout when no rising
// edge arrives while armed.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high
//   enable_in    measurement enable (asynchronous, synchronized here)
//   pwm_in       PWM signal under test (asynchronous, synchronized here)
//   width_out    last measured high time in clk cycles
//   width_valid  one-cycle strobe: new result on width_out / level_* / overflow
//   level_high   last result above HIGH_COUNTER_VALUE
//   level_low    last result below LOW_COUNTER_VALUE
//   overflow     last result saturated at MAX_COUNTER_VALUE
//   timeout      one-cycle strobe: no rising edge for TIMEOUT_CYCLES while armed
//   busy         high in every state except IDLE
module pwm_measure_sequencer #(
    parameter int MAX_COUNTER_VALUE  = 2000,
    parameter int HIGH_COUNTER_VALUE = 1900,
    parameter int LOW_COUNTER_VALUE  = 1100,
    parameter int TIMEOUT_CYCLES     = 25000,
    parameter int CNT_W              = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_in,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] width_out,
    output logic             width_valid,
    output logic             level_high,
    output logic             level_low,
    output logic             overflow,
    output logic             timeout,
    output logic             busy
);

    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_COUNTER_VALUE);
    localparam logic [CNT_W-1:0] HIGH_C = CNT_W'(HIGH_COUNTER_VALUE);
    localparam logic [CNT_W-1:0] LOW_C  = CNT_W'(LOW_COUNTER_VALUE);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT_RISE,
        MEASURE,
        REPORT
    } state_t;

    state_t state, state_n;

    logic             enable_sync1, enable_s;
    logic             pwm_sync1, pwm_s, pwm_d;
    logic             rise;

    logic [CNT_W-1:0] cnt, cnt_n;
    logic             ovf_flag, ovf_flag_n;
    logic [TO_W-1:0]  tcnt, tcnt_n;

    logic [CNT_W-1:0] width_n;
    logic             valid_n, high_n, low_n, overflow_n, timeout_n, busy_n;

    assign rise = pwm_s & ~pwm_d;

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        ovf_flag_n = ovf_flag;
        tcnt_n     = tcnt;
        width_n    = width_out;
        high_n     = level_high;
        low_n      = level_low;
        overflow_n = overflow;
        valid_n    = 1'b0;
        timeout_n  = 1'b0;

        if (!enable_s) begin
            // Dropping enable abandons any measurement silently; the last
            // result stays on the outputs.
            state_n    = IDLE;
            cnt_n      = '0;
            ovf_flag_n = 1'b0;
            tcnt_n     = '0;
        end else begin
            case (state)
                IDLE: begin
                    tcnt_n  = '0;
                    state_n = ARM;
                end
                ARM, WAIT_RISE: begin
                    if (state == WAIT_RISE && rise) begin
                        state_n    = MEASURE;
                        cnt_n      = CNT_W'(1);
                        ovf_flag_n = 1'b0;
                        tcnt_n     = '0;
                    end else begin
                        // ARM only leaves once the input is low, so a pulse
                        // already in progress is never measured.
                        if (state == ARM && !pwm_s) begin
                            state_n = WAIT_RISE;
                        end
                        if (tcnt == TO_LAST) begin
                            tcnt_n     = '0;
                            timeout_n  = 1'b1;
                            width_n    = '0;
                            high_n     = 1'b0;
                            low_n      = 1'b0;
                            overflow_n = 1'b0;
                        end else begin
                            tcnt_n = tcnt + 1'b1;
                        end
                    end
                end
                MEASURE: begin
                    // pwm_d is always high here, so a low pwm_s is the falling
                    // edge; it wins over saturation in the same cycle.
                    if (!pwm_s) begin
                        state_n = REPORT;
                    end else if (cnt == MAX_C) begin
                        state_n    = REPORT;
                        ovf_flag_n = 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                REPORT: begin
                    width_n    = cnt;
                    valid_n    = 1'b1;
                    high_n     = (cnt > HIGH_C);
                    low_n      = (cnt < LOW_C);
                    overflow_n = ovf_flag;
                    cnt_n      = '0;
                    ovf_flag_n = 1'b0;
                    state_n    = ARM;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enable_sync1 <= 1'b0;
            enable_s     <= 1'b0;
            pwm_sync1    <= 1'b0;
            pwm_s        <= 1'b0;
            pwm_d        <= 1'b0;
            state        <= IDLE;
            cnt          <= '0;
            ovf_flag     <= 1'b0;
            tcnt         <= '0;
            width_out    <= '0;
            width_valid  <= 1'b0;
            level_high   <= 1'b0;
            level_low    <= 1'b0;
            overflow     <= 1'b0;
            timeout      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            enable_sync1 <= enable_in;
            enable_s     <= enable_sync1;
            pwm_sync1    <= pwm_in;
            pwm_s        <= pwm_sync1;
            pwm_d        <= pwm_s;
            state        <= state_n;
            cnt          <= cnt_n;
            ovf_flag     <= ovf_flag_n;
            tcnt         <= tcnt_n;
            width_out    <= width_n;
            width_valid  <= valid_n;
            level_high   <= high_n;
            level_low    <= low_n;
            overflow     <= overflow_n;
            timeout      <= timeout_n;
            busy         <= busy_n;
        end
    end

endmodule

// File: tb/tb_pwm_measure_sequencer.sv
// tb/tb_pwm_measure_sequencer.sv - scoreboard bench for pwm_measure_sequencer
module tb_pwm_measure_sequencer;

    localparam int MAXV = 2000;
    localparam int HIGHV = 1900;
    localparam int LOWV = 1100;
    localparam int TOUT = 25000;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable_in;
    logic        pwm_in;
    logic [10:0] width_out;
    logic        width_valid;
    logic        level_high;
    logic        level_low;
    logic        overflow;
    logic        timeout;
    logic        busy;

    pwm_measure_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .enable_in   (enable_in),
        .pwm_in      (pwm_in),
        .width_out   (width_out),
        .width_valid (width_valid),
        .level_high  (level_high),
        .level_low   (level_low),
        .overflow    (overflow),
        .timeout     (timeout),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int width;
        int hi;
        int lo;
        int ovf;
        int t;
    } exp_t;

    exp_t exp_q[$];
    int   to_lo_q[$];
    int   to_hi_q[$];

    int cyc = 0;
    int n_cmp = 0;
    int n_fail = 0;
    int last_t = 0;
    int last_to = 0;
    int to_seen = 0;
    exp_t e;
    int lo_w, hi_w;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: pops expectations whenever the DUT presents a strobe.
    always @(negedge clk) begin
        if (!rst) begin
            if (width_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: got width %0d, expected no strobe (cycle %0d)", width_out, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("width", int'(width_out), e.width);
                    chk("level_high", int'(level_high), e.hi);
                    chk("level_low", int'(level_low), e.lo);
                    chk("overflow", int'(overflow), e.ovf);
                    chk("strobe_cycle", cyc, e.t);
                end
            end
            if (timeout) begin
                last_to = cyc;
                to_seen++;
                if (to_lo_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_timeout: got timeout at cycle %0d, expected none", cyc);
                end else begin
                    lo_w = to_lo_q.pop_front();
                    hi_w = to_hi_q.pop_front();
                    n_cmp++;
                    if (cyc < lo_w || cyc > hi_w) begin
                        n_fail++;
                        $display("FAIL timeout_cycle: got %0d, expected %0d..%0d", cyc, lo_w, hi_w);
                    end
                    chk("timeout_width_clr", int'(width_out), 0);
                    chk("timeout_high_clr", int'(level_high), 0);
                    chk("timeout_low_clr", int'(level_low), 0);
                    chk("timeout_ovf_clr", int'(overflow), 0);
                    chk("timeout_busy", int'(busy), 1);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int w, input int gap);
        exp_t x;
        int we;
        we = (w > MAXV) ? MAXV : w;
        x.width = we;
        x.hi = (we > HIGHV) ? 1 : 0;
        x.lo = (we < LOWV) ? 1 : 0;
        x.ovf = (w > MAXV) ? 1 : 0;
        x.t = cyc + we + 4;
        exp_q.push_back(x);
        last_t = x.t;
        pwm_in = 1'b1;
        step(w / 2);
        chk("busy_mid_pulse", int'(busy), 1);
        step(w - w / 2);
        pwm_in = 1'b0;
        step(gap);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            step(1);
            k++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_width"}, int'(width_out), 0);
        chk({name, "_valid"}, int'(width_valid), 0);
        chk({name, "_high"}, int'(level_high), 0);
        chk({name, "_low"}, int'(level_low), 0);
        chk({name, "_ovf"}, int'(overflow), 0);
        chk({name, "_timeout"}, int'(timeout), 0);
        chk({name, "_busy"}, int'(busy), 0);
    endtask

    task automatic wait_timeouts(input int target, input string name);
        int k;
        k = 0;
        while (to_seen < target && k < TOUT + 200) begin
            step(1);
            k++;
        end
        chk(name, to_seen, target);
    endtask

    initial begin
        int directed[10];
        directed = '{1000, 1950, 1500, 1100, 1900, 1099, 1901, 2000, 2001, 2500};

        rst = 1'b1;
        enable_in = 1'b0;
        pwm_in = 1'b0;
        step(200);
        check_all_zero("reset");
        rst = 1'b0;
        enable_in = 1'b1;
        step(20);

        // Directed widths around every classification and saturation boundary.
        foreach (directed[i]) pulse(directed[i], 30);
        drain("directed_drained");

        // Randomized widths and gaps.
        for (int i = 0; i < 4; i++) begin
            pulse(int'($urandom_range(1, 2300)), int'($urandom_range(8, 40)));
        end
        drain("random_drained");

        // Pulse already in progress when enable rises is ignored.
        enable_in = 1'b0;
        step(10);
        chk("busy_disabled", int'(busy), 0);
        pwm_in = 1'b1;
        step(10);
        enable_in = 1'b1;
        step(300);
        pwm_in = 1'b0;
        step(20);
        pulse(1200, 30);
        drain("preexisting_drained");

        // No rising edge: periodic timeout, results cleared, busy held.
        to_lo_q.push_back(last_t + TOUT - 4);
        to_hi_q.push_back(last_t + TOUT + 4);
        wait_timeouts(1, "first_timeout_seen");
        to_lo_q.push_back(last_to + TOUT);
        to_hi_q.push_back(last_to + TOUT);
        wait_timeouts(2, "second_timeout_seen");
        chk("busy_after_timeouts", int'(busy), 1);

        // Enable drops mid-pulse: no strobe, result held, busy clears.
        pulse(1500, 30);
        drain("held_result_drained");
        pwm_in = 1'b1;
        step(500);
        enable_in = 1'b0;
        step(5);
        chk("abort_busy", int'(busy), 0);
        chk("abort_width_held", int'(width_out), 1500);
        chk("abort_high_held", int'(level_high), 0);
        chk("abort_low_held", int'(level_low), 0);
        step(100);
        pwm_in = 1'b0;
        step(20);

        // Reset mid-pulse clears everything.
        enable_in = 1'b1;
        step(10);
        pwm_in = 1'b1;
        step(300);
        rst = 1'b1;
        step(1);
        check_all_zero("midreset");
        rst = 1'b0;
        pwm_in = 1'b0;
        enable_in = 1'b0;
        step(50);

        chk("pending_results", exp_q.size(), 0);
        chk("pending_timeouts", to_lo_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #(10 * 95000);
        $display("FAIL watchdog: got no completion, expected finish within 95000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule
